stack_ctrl: RTL

- Sequencer between the 8080 execute stage and the memory block's stack port.
- Turns stack-class instructions (PUSH, POP, CALL, RET, RST, XTHL, SPHL, LXI SP) into one-cycle push/pop/swap/replace_SP strobes.
- Captures the registered pop/swap data and returns results and branch targets to execute.
- Keeps a shadow SP that mirrors the memory's stack_top, and flags overflow and underflow.

---
 rtl/stack_pkg.sv | 42 ++++
 rtl/stack_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the 8080 stack sequencer: op codes, FSM states,
// default stack bounds and the latched request record.
package stack_pkg;

    localparam logic [15:0] SP_RESET_DEF    = 16'hFFFF;
    localparam logic [15:0] STACK_LIMIT_DEF = 16'hBFFF;
    // Any SP above this would wrap past 16'hFFFF on a pop.
    localparam logic [15:0] UDF_THRESH      = 16'hFFFD;

    typedef enum logic [2:0] {
        OP_PUSH  = 3'd0,
        OP_POP   = 3'd1,
        OP_CALL  = 3'd2,
        OP_RET   = 3'd3,
        OP_XTHL  = 3'd4,
        OP_SPHL  = 3'd5,
        OP_RST   = 3'd6,
        OP_LXISP = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_CAPT,
        ST_DONE
    } state_e;

    typedef struct packed {
        op_e         op;
        logic [15:0] data;
        logic [15:0] pc;
        logic [2:0]  rstn;
        logic        cond;
    } req_t;

    // RST n jumps to n*8.
    function automatic logic [15:0] rst_vector(input logic [2:0] n);
        return {10'b0, n, 3'b000};
    endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Stack sequencer: turns execute-stage stack ops into single memory strobes,
// captures popped data, tracks a shadow SP and sticky over/underflow flags.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter logic [15:0] SP_RESET    = SP_RESET_DEF,
    parameter logic [15:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_data,
    input  logic [15:0] req_pc,
    input  logic [2:0]  req_rstn,
    input  logic        req_cond,
    output logic        done,
    output logic [15:0] result,
    output logic        pc_load,
    output logic [15:0] pc_target,
    output logic [15:0] sp_q,
    output logic        err_ovf,
    output logic        err_udf,
    input  logic        clr_err,
    output logic        mem_push,
    output logic        mem_pop,
    output logic        mem_swap,
    output logic        mem_replace_sp,
    output logic [15:0] mem_data,
    input  logic [15:0] mem_out
);

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic [15:0] sp_d, result_q, result_d, pct_q, pct_d;
    logic        abort_q, abort_d, ovf_q, ovf_d, udf_q, udf_d;
    logic        do_push, do_pop, do_swap, do_repl, want_pop, udf_hit;
    logic        push_pc, jump_op;
    logic [15:0] sp_dec;

    assign result    = result_q;
    assign pc_target = pct_q;
    assign err_ovf   = ovf_q;
    assign err_udf   = udf_q;
    assign sp_dec    = sp_q - 16'd2;

    // Decode the latched op into the single memory action it needs.
    always_comb begin
        want_pop = (req_q.op == OP_POP) || (req_q.op == OP_RET && req_q.cond);
        udf_hit  = want_pop && (sp_q > UDF_THRESH);
        do_pop   = want_pop && !udf_hit;
        push_pc  = (req_q.op == OP_CALL && req_q.cond) || (req_q.op == OP_RST);
        do_push  = (req_q.op == OP_PUSH) || push_pc;
        do_swap  = (req_q.op == OP_XTHL);
        do_repl  = (req_q.op == OP_SPHL) || (req_q.op == OP_LXISP);
        jump_op  = ((req_q.op == OP_CALL || req_q.op == OP_RET) && req_q.cond) ||
                   (req_q.op == OP_RST);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_INIT;
        else        state_q <= state_d;
    end

    // FSM next state: pop/swap need an extra cycle to capture registered data.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  state_d = ST_IDLE;
            ST_IDLE:  if (req_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = (do_pop || do_swap) ? ST_CAPT : ST_DONE;
            ST_CAPT:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_INIT;
        endcase
    end

    // FSM outputs; the INIT resync strobe is held off while reset is asserted.
    always_comb begin
        req_ready      = (state_q == ST_IDLE);
        done           = (state_q == ST_DONE);
        pc_load        = (state_q == ST_DONE) && jump_op && !abort_q;
        mem_push       = 1'b0;
        mem_pop        = 1'b0;
        mem_swap       = 1'b0;
        mem_replace_sp = 1'b0;
        mem_data       = '0;
        case (state_q)
            ST_INIT: begin
                mem_replace_sp = rst_n;
                mem_data       = rst_n ? SP_RESET : 16'h0000;
            end
            ST_ISSUE: begin
                mem_push       = do_push;
                mem_pop        = do_pop;
                mem_swap       = do_swap;
                mem_replace_sp = do_repl;
                if (push_pc)                          mem_data = req_q.pc;
                else if (do_push || do_swap || do_repl) mem_data = req_q.data;
            end
            default: ;
        endcase
    end

    // Datapath next values: request latch, shadow SP, result/target, error flags.
    always_comb begin
        logic ovf_set, udf_set;
        req_d    = req_q;
        sp_d     = sp_q;
        result_d = result_q;
        pct_d    = pct_q;
        abort_d  = abort_q;
        ovf_set  = 1'b0;
        udf_set  = 1'b0;
        case (state_q)
            ST_INIT: sp_d = SP_RESET;
            ST_IDLE: begin
                if (req_valid) begin
                    req_d.op   = op_e'(req_op);
                    req_d.data = req_data;
                    req_d.pc   = req_pc;
                    req_d.rstn = req_rstn;
                    req_d.cond = req_cond;
                    abort_d    = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (do_push) begin
                    sp_d    = sp_dec;
                    ovf_set = (sp_dec < STACK_LIMIT);
                end else if (do_pop) begin
                    sp_d = sp_q + 16'd2;
                end else if (do_repl) begin
                    sp_d = req_q.data;
                end
                if (req_q.op == OP_CALL && req_q.cond) pct_d = req_q.data;
                if (req_q.op == OP_RST)                pct_d = rst_vector(req_q.rstn);
                if (udf_hit) begin
                    result_d = '0;
                    udf_set  = 1'b1;
                    abort_d  = 1'b1;
                end
            end
            ST_CAPT: begin
                result_d = mem_out;
                if (req_q.op == OP_RET) pct_d = mem_out;
            end
            default: ;
        endcase
        // A flag that sets in the same cycle as clr_err stays set.
        ovf_d = (ovf_q && !clr_err) || ovf_set;
        udf_d = (udf_q && !clr_err) || udf_set;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= '0;
            sp_q     <= SP_RESET;
            result_q <= '0;
            pct_q    <= '0;
            abort_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            req_q    <= req_d;
            sp_q     <= sp_d;
            result_q <= result_d;
            pct_q    <= pct_d;
            abort_q  <= abort_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

endmodule
